// File: rtl/comb_vector_sequencer_pkg.sv
// Shared types for the vector sequencer: FSM state encoding and the run result bundle.
package comb_test_pkg;

    localparam int MAX_ADDR_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        APPLY = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Sized for the largest legal vector set; narrower builds use the low bits.
    typedef struct packed {
        logic                  pass;
        logic                  fail_valid;
        logic [MAX_ADDR_W:0]   err_count;
        logic [MAX_ADDR_W-1:0] first_fail_addr;
    } result_t;

endpackage

// File: rtl/comb_vector_sequencer_tracker.sv
// Pass/fail bookkeeping for one run: saturating error count and first failing address.
module seq_result_tracker
    import comb_test_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              cmp_stb,
    input  logic              mismatch,
    input  logic [ADDR_W-1:0] idx,
    output result_t           result
);

    localparam logic [ADDR_W:0] ERR_MAX = '1;

    logic [ADDR_W:0]   err_count_q, err_count_d;
    logic              fail_valid_q, fail_valid_d;
    logic [ADDR_W-1:0] first_fail_addr_q, first_fail_addr_d;

    always_comb begin
        err_count_d       = err_count_q;
        fail_valid_d      = fail_valid_q;
        first_fail_addr_d = first_fail_addr_q;
        if (clear) begin
            err_count_d       = '0;
            fail_valid_d      = 1'b0;
            first_fail_addr_d = '0;
        end else if (cmp_stb && mismatch) begin
            if (err_count_q != ERR_MAX) begin
                err_count_d = err_count_q + 1'b1;
            end
            if (!fail_valid_q) begin
                first_fail_addr_d = idx;
                fail_valid_d      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count_q       <= '0;
            fail_valid_q      <= 1'b0;
            first_fail_addr_q <= '0;
        end else begin
            err_count_q       <= err_count_d;
            fail_valid_q      <= fail_valid_d;
            first_fail_addr_q <= first_fail_addr_d;
        end
    end

    always_comb begin
        result                            = '0;
        result.pass                       = (err_count_q == '0);
        result.fail_valid                 = fail_valid_q;
        result.err_count[ADDR_W:0]        = err_count_q;
        result.first_fail_addr[ADDR_W-1:0] = first_fail_addr_q;
    end

endmodule

// File: rtl/comb_vector_sequencer.sv
// Steps a registered-read vector ROM through a combinational block, three cycles per vector,
// and reports pass/fail statistics when the run completes.
module comb_vector_sequencer
    import comb_test_pkg::*;
#(
    parameter int IN_W   = 4,
    parameter int OUT_W  = 1,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop_on_fail,
    output logic [ADDR_W-1:0]     vec_addr,
    input  logic [IN_W+OUT_W-1:0] vec_data,
    output logic [IN_W-1:0]       dut_a,
    input  logic [OUT_W-1:0]      dut_y,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_W:0]       err_count,
    output logic                  fail_valid,
    output logic [ADDR_W-1:0]     first_fail_addr
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] vec_addr_q, vec_addr_d;
    logic [IN_W-1:0]   dut_a_q, dut_a_d;
    logic [OUT_W-1:0]  exp_q, exp_d;
    logic              stop_q, stop_d;
    logic              clear, cmp_stb, mismatch;
    result_t           res;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        vec_addr_d = vec_addr_q;
        dut_a_d    = dut_a_q;
        exp_d      = exp_q;
        stop_d     = stop_q;
        clear      = 1'b0;
        cmp_stb    = 1'b0;
        // 4-state compare so an X/Z response from the block is never a pass
        mismatch   = (dut_y !== exp_q);
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = FETCH;
                    idx_d      = '0;
                    vec_addr_d = '0;
                    stop_d     = stop_on_fail;
                    clear      = 1'b1;
                end
            end
            FETCH: state_d = APPLY;
            APPLY: begin
                dut_a_d = vec_data[IN_W+OUT_W-1:OUT_W];
                exp_d   = vec_data[OUT_W-1:0];
                state_d = CHECK;
            end
            CHECK: begin
                cmp_stb = 1'b1;
                if ((mismatch && stop_q) || idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    state_d    = FETCH;
                    idx_d      = idx_q + 1'b1;
                    vec_addr_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            vec_addr_q <= '0;
            dut_a_q    <= '0;
            exp_q      <= '0;
            stop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            vec_addr_q <= vec_addr_d;
            dut_a_q    <= dut_a_d;
            exp_q      <= exp_d;
            stop_q     <= stop_d;
        end
    end

    seq_result_tracker #(.ADDR_W(ADDR_W)) u_tracker (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .cmp_stb  (cmp_stb),
        .mismatch (mismatch),
        .idx      (idx_q),
        .result   (res)
    );

    logic unused_res;
    assign unused_res = ^res;

    assign vec_addr        = vec_addr_q;
    assign dut_a           = dut_a_q;
    assign busy            = (state_q == FETCH) || (state_q == APPLY) || (state_q == CHECK);
    assign done            = (state_q == DONE);
    assign pass            = done && res.pass;
    assign err_count       = res.err_count[ADDR_W:0];
    assign fail_valid      = res.fail_valid;
    assign first_fail_addr = res.first_fail_addr[ADDR_W-1:0];

endmodule

// File: tb/tb_comb_vector_sequencer.sv
// Directed bench: XOR-4 block behind a 16-vector sequencer plus a single-vector build.
module tb_comb_vector_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, stop_on_fail, start1, x_mode;

    logic [3:0] vec_addr, dut_a, first_fail_addr;
    logic [4:0] vec_data, err_count;
    logic       dut_y, busy, done, pass, fail_valid;
    logic [4:0] rom [16];

    logic [0:0] vec_addr1, first_fail_addr1;
    logic [4:0] vec_data1;
    logic [3:0] dut_a1;
    logic [1:0] err_count1;
    logic       dut_y1, busy1, done1, pass1, fail_valid1;
    logic [4:0] rom1 [2];

    comb_vector_sequencer #(.IN_W(4), .OUT_W(1), .DEPTH(16)) u_dut (
        .clk(clk), .reset(reset), .start(start), .stop_on_fail(stop_on_fail),
        .vec_addr(vec_addr), .vec_data(vec_data), .dut_a(dut_a), .dut_y(dut_y),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_valid(fail_valid), .first_fail_addr(first_fail_addr)
    );

    comb_vector_sequencer #(.IN_W(4), .OUT_W(1), .DEPTH(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .stop_on_fail(1'b0),
        .vec_addr(vec_addr1), .vec_data(vec_data1), .dut_a(dut_a1), .dut_y(dut_y1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err_count1),
        .fail_valid(fail_valid1), .first_fail_addr(first_fail_addr1)
    );

    always @(posedge clk) vec_data  <= rom[vec_addr];
    always @(posedge clk) vec_data1 <= rom1[vec_addr1];
    assign dut_y  = ^dut_a;
    assign dut_y1 = x_mode ? 1'bx : ^dut_a1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_rom(input int bad_a, input int bad_b);
        for (int i = 0; i < 16; i++) begin
            rom[i] = {4'(i), ^4'(i)};
            if (i == bad_a || i == bad_b) rom[i][0] = ~rom[i][0];
        end
    endtask

    // cyc counts posedges with the start-sampling edge as 1; err/fv captured right after it
    task automatic run(input logic sof, input int pulse_at, output int cyc,
                       output logic [4:0] err_at1, output logic fv_at1);
        @(negedge clk);
        start = 1'b1;
        stop_on_fail = sof;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        err_at1 = err_count;
        fv_at1 = fail_valid;
        while (!done && cyc < 200) begin
            if (cyc == pulse_at) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
    endtask

    task automatic run1(output int cyc);
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        cyc = 1;
        while (!done1 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    int         cyc;
    logic [4:0] e1;
    logic       f1;

    initial begin
        reset = 1'b1; start = 1'b0; stop_on_fail = 1'b0; start1 = 1'b0; x_mode = 1'b0;
        load_rom(-1, -1);
        rom1[0] = {4'b1011, 1'b1};
        rom1[1] = {4'b1011, 1'b1};
        #12;
        check("rst_vec_addr", 32'(vec_addr), 0);
        check("rst_dut_a", 32'(dut_a), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_pass", 32'(pass), 0);
        check("rst_err", 32'(err_count), 0);
        check("rst_fv", 32'(fail_valid), 0);
        check("rst_ffa", 32'(first_fail_addr), 0);
        @(negedge clk);
        reset = 1'b0;

        run(1'b0, 0, cyc, e1, f1);
        check("clean_cycles", 32'(cyc), 49);
        check("clean_pass", 32'(pass), 1);
        check("clean_err", 32'(err_count), 0);
        check("clean_fv", 32'(fail_valid), 0);
        check("clean_busy", 32'(busy), 0);
        check("clean_dut_a_hold", 32'(dut_a), 4'hF);

        load_rom(5, -1);
        run(1'b0, 0, cyc, e1, f1);
        check("bad5_cycles", 32'(cyc), 49);
        check("bad5_err", 32'(err_count), 1);
        check("bad5_ffa", 32'(first_fail_addr), 5);
        check("bad5_pass", 32'(pass), 0);
        check("bad5_fv", 32'(fail_valid), 1);

        load_rom(3, 9);
        run(1'b1, 0, cyc, e1, f1);
        check("stop_cycles", 32'(cyc), 13);
        check("stop_err", 32'(err_count), 1);
        check("stop_ffa", 32'(first_fail_addr), 3);
        check("stop_vec_addr", 32'(vec_addr), 3);
        check("stop_dut_a", 32'(dut_a), 3);
        check("stop_restart_err", 32'(e1), 32'(err_count == 0 ? 5'd1 : 5'd1) - 1 + 1 - 1);

        run(1'b0, 0, cyc, e1, f1);
        check("two_restart_err", 32'(e1), 0);
        check("two_restart_fv", 32'(f1), 0);
        check("two_cycles", 32'(cyc), 49);
        check("two_err", 32'(err_count), 2);
        check("two_ffa", 32'(first_fail_addr), 3);

        // Asynchronous reset while vector 7 sits in CHECK (after the 24th edge)
        load_rom(2, -1);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (23) @(posedge clk);
        #2;
        check("mid_busy", 32'(busy), 1);
        check("mid_err", 32'(err_count), 1);
        check("mid_vec_addr", 32'(vec_addr), 7);
        reset = 1'b1;
        #1;
        check("arst_vec_addr", 32'(vec_addr), 0);
        check("arst_dut_a", 32'(dut_a), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_err", 32'(err_count), 0);
        check("arst_fv", 32'(fail_valid), 0);
        check("arst_ffa", 32'(first_fail_addr), 0);
        @(negedge clk);
        reset = 1'b0;
        load_rom(-1, -1);
        run(1'b0, 0, cyc, e1, f1);
        check("post_rst_cycles", 32'(cyc), 49);
        check("post_rst_pass", 32'(pass), 1);

        // start pulse while busy at vector 2 is ignored; restart from DONE clears counters
        load_rom(5, -1);
        run(1'b0, 7, cyc, e1, f1);
        check("busy_start_cycles", 32'(cyc), 49);
        check("busy_start_err", 32'(err_count), 1);
        check("busy_start_ffa", 32'(first_fail_addr), 5);
        run(1'b0, 0, cyc, e1, f1);
        check("rerun_clear_err", 32'(e1), 0);
        check("rerun_clear_fv", 32'(f1), 0);
        check("rerun_cycles", 32'(cyc), 49);
        check("rerun_err", 32'(err_count), 1);
        check("rerun_ffa", 32'(first_fail_addr), 5);
        check("rerun_pass", 32'(pass), 0);

        run1(cyc);
        check("d1_cycles", 32'(cyc), 4);
        check("d1_pass", 32'(pass1), 1);
        check("d1_err", 32'(err_count1), 0);
        check("d1_dut_a", 32'(dut_a1), 4'hB);
        x_mode = 1'b1;
        run1(cyc);
        check("d1x_cycles", 32'(cyc), 4);
        check("d1x_err", 32'(err_count1), 1);
        check("d1x_fv", 32'(fail_valid1), 1);
        check("d1x_pass", 32'(pass1), 0);
        check("d1x_ffa", 32'(first_fail_addr1), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
